// File: rtl/mips_main.sv
// Five-stage MIPS-subset core (IF, ID, EX, MEM, WB) with no forwarding or hazard logic.
// Software keeps dependent instructions at least four slots apart.
module mips_main (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  instruction_mem [255:0],
  output logic [31:0] next_instruction,
  output logic [31:0] alu_result
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  localparam logic [1:0] LD_NONE = 2'd0;
  localparam logic [1:0] LD_W    = 2'd1;
  localparam logic [1:0] LD_H    = 2'd2;
  localparam logic [1:0] LD_HU   = 2'd3;

  function automatic logic signed [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic signed [31:0] alu_calc(input logic [1:0] op,
                                                  input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [1:0] kind, input logic [31:0] word);
    case (kind)
      LD_H:    return {{16{word[15]}}, word[15:0]};
      LD_HU:   return {16'h0000, word[15:0]};
      default: return word;
    endcase
  endfunction

  logic [7:0]  pc_q, pc_d;
  logic [31:0] instr_p0_q, instr_p0_d;

  logic               en_p1_q, en_p1_d;
  logic [1:0]         alu_op_p1_q, alu_op_p1_d;
  logic               use_imm_p1_q, use_imm_p1_d;
  logic signed [31:0] a_p1_q, a_p1_d;
  logic signed [31:0] b_p1_q, b_p1_d;
  logic signed [31:0] imm_p1_q, imm_p1_d;
  logic [4:0]         dst_p1_q, dst_p1_d;
  logic               rw_p1_q, rw_p1_d;
  logic               mem_wr_p1_q, mem_wr_p1_d;
  logic [1:0]         ld_p1_q, ld_p1_d;

  logic [31:0] alu_p2_q, alu_p2_d;
  logic [31:0] sd_p2_q, sd_p2_d;
  logic [4:0]  dst_p2_q, dst_p2_d;
  logic        rw_p2_q, rw_p2_d;
  logic        mem_wr_p2_q, mem_wr_p2_d;
  logic [1:0]  ld_p2_q, ld_p2_d;

  logic [31:0] wb_p3_q, wb_p3_d;
  logic [4:0]  dst_p3_q, dst_p3_d;
  logic        rw_p3_q, rw_p3_d;

  logic [31:0] rf_q [32];
  logic [7:0]  dmem_q [256];

  logic [5:0]         op, funct;
  logic [4:0]         rs, rt, rd;
  logic signed [31:0] alu_val;
  logic [7:0]         mem_addr;
  logic [31:0]        mem_word;
  logic               rf_we;

  assign op    = instr_p0_q[31:26];
  assign rs    = instr_p0_q[25:21];
  assign rt    = instr_p0_q[20:16];
  assign rd    = instr_p0_q[15:11];
  assign funct = instr_p0_q[5:0];

  // IF: little-endian fetch, PC wraps naturally at 8 bits
  always_comb begin
    pc_d       = pc_q + 8'd4;
    instr_p0_d = {instruction_mem[pc_q + 8'd3], instruction_mem[pc_q + 8'd2],
                  instruction_mem[pc_q + 8'd1], instruction_mem[pc_q]};
  end

  // ID: decode and combinational register read (no write-through bypass)
  always_comb begin
    en_p1_d      = 1'b0;
    alu_op_p1_d  = ALU_ADD;
    use_imm_p1_d = 1'b1;
    dst_p1_d     = rt;
    rw_p1_d      = 1'b0;
    mem_wr_p1_d  = 1'b0;
    ld_p1_d      = LD_NONE;
    case (op)
      OP_RTYPE: begin
        use_imm_p1_d = 1'b0;
        dst_p1_d     = rd;
        en_p1_d      = (funct == FN_ADD) || (funct == FN_SUB) ||
                       (funct == FN_AND) || (funct == FN_OR);
        rw_p1_d      = en_p1_d;
        case (funct)
          FN_SUB:  alu_op_p1_d = ALU_SUB;
          FN_AND:  alu_op_p1_d = ALU_AND;
          FN_OR:   alu_op_p1_d = ALU_OR;
          default: alu_op_p1_d = ALU_ADD;
        endcase
      end
      OP_ADDI: begin
        en_p1_d = 1'b1;
        rw_p1_d = 1'b1;
      end
      OP_LW: begin
        en_p1_d = 1'b1;
        rw_p1_d = 1'b1;
        ld_p1_d = LD_W;
      end
      OP_LH: begin
        en_p1_d = 1'b1;
        rw_p1_d = 1'b1;
        ld_p1_d = LD_H;
      end
      OP_LHU: begin
        en_p1_d = 1'b1;
        rw_p1_d = 1'b1;
        ld_p1_d = LD_HU;
      end
      OP_SW: begin
        en_p1_d     = 1'b1;
        mem_wr_p1_d = 1'b1;
      end
      default: ;
    endcase
    a_p1_d   = rf_q[rs];
    b_p1_d   = rf_q[rt];
    imm_p1_d = sext16(instr_p0_q[15:0]);
  end

  // EX: unsupported encodings are forced to a zero result
  always_comb begin
    alu_val     = alu_calc(alu_op_p1_q, a_p1_q, use_imm_p1_q ? imm_p1_q : b_p1_q);
    alu_p2_d    = en_p1_q ? alu_val : 32'h0;
    sd_p2_d     = b_p1_q;
    dst_p2_d    = dst_p1_q;
    rw_p2_d     = rw_p1_q;
    mem_wr_p2_d = mem_wr_p1_q;
    ld_p2_d     = ld_p1_q;
  end

  // MEM: byte addresses wrap mod 256, unaligned access allowed
  always_comb begin
    mem_addr = alu_p2_q[7:0];
    mem_word = {dmem_q[mem_addr + 8'd3], dmem_q[mem_addr + 8'd2],
                dmem_q[mem_addr + 8'd1], dmem_q[mem_addr]};
    wb_p3_d  = (ld_p2_q != LD_NONE) ? load_fmt(ld_p2_q, mem_word) : alu_p2_q;
    dst_p3_d = dst_p2_q;
    rw_p3_d  = rw_p2_q;
  end

  // WB: $0 is never written
  always_comb begin
    rf_we = rw_p3_q && (dst_p3_q != 5'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= '0;
      instr_p0_q   <= '0;
      en_p1_q      <= 1'b0;
      alu_op_p1_q  <= ALU_ADD;
      use_imm_p1_q <= 1'b0;
      a_p1_q       <= '0;
      b_p1_q       <= '0;
      imm_p1_q     <= '0;
      dst_p1_q     <= '0;
      rw_p1_q      <= 1'b0;
      mem_wr_p1_q  <= 1'b0;
      ld_p1_q      <= LD_NONE;
      alu_p2_q     <= '0;
      sd_p2_q      <= '0;
      dst_p2_q     <= '0;
      rw_p2_q      <= 1'b0;
      mem_wr_p2_q  <= 1'b0;
      ld_p2_q      <= LD_NONE;
      wb_p3_q      <= '0;
      dst_p3_q     <= '0;
      rw_p3_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      instr_p0_q   <= instr_p0_d;
      en_p1_q      <= en_p1_d;
      alu_op_p1_q  <= alu_op_p1_d;
      use_imm_p1_q <= use_imm_p1_d;
      a_p1_q       <= a_p1_d;
      b_p1_q       <= b_p1_d;
      imm_p1_q     <= imm_p1_d;
      dst_p1_q     <= dst_p1_d;
      rw_p1_q      <= rw_p1_d;
      mem_wr_p1_q  <= mem_wr_p1_d;
      ld_p1_q      <= ld_p1_d;
      alu_p2_q     <= alu_p2_d;
      sd_p2_q      <= sd_p2_d;
      dst_p2_q     <= dst_p2_d;
      rw_p2_q      <= rw_p2_d;
      mem_wr_p2_q  <= mem_wr_p2_d;
      ld_p2_q      <= ld_p2_d;
      wb_p3_q      <= wb_p3_d;
      dst_p3_q     <= dst_p3_d;
      rw_p3_q      <= rw_p3_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_q <= '{default: '0};
    end else if (rf_we) begin
      rf_q[dst_p3_q] <= wb_p3_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_q <= '{default: '0};
    end else if (mem_wr_p2_q) begin
      dmem_q[mem_addr]        <= sd_p2_q[7:0];
      dmem_q[mem_addr + 8'd1] <= sd_p2_q[15:8];
      dmem_q[mem_addr + 8'd2] <= sd_p2_q[23:16];
      dmem_q[mem_addr + 8'd3] <= sd_p2_q[31:24];
    end
  end

  assign next_instruction = instr_p0_q;
  assign alu_result       = alu_p2_q;

endmodule

// File: tb/tb_mips_main.sv
// Directed program bench for mips_main: register values are exposed on alu_result
// through later "or $0,$rX,$0" instructions, each output checked every cycle.
module tb_mips_main;

  logic        clk;
  logic        rst;
  logic [7:0]  imem [255:0];
  logic [31:0] next_instruction;
  logic [31:0] alu_result;

  logic [31:0] prog    [64];
  logic [31:0] exp_alu [64];
  int n_cmp;
  int n_bad;

  mips_main dut (
    .clk             (clk),
    .reset           (rst),
    .instruction_mem (imem),
    .next_instruction(next_instruction),
    .alu_result      (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic run_pass(input int ncyc, input string pfx);
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s next_instruction E%0d", pfx, n), next_instruction, prog[n-1]);
      chk($sformatf("%s alu_result E%0d", pfx, n), alu_result,
          (n >= 3) ? exp_alu[n-3] : 32'h0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    for (int k = 0; k < 64; k++) begin
      prog[k]    = 32'h0;
      exp_alu[k] = 32'h0;
    end

    prog[0]  = ri(6'h08, 5'd0,  5'd10, 16'd10);     exp_alu[0]  = 32'd10;
    prog[1]  = ri(6'h08, 5'd0,  5'd12, 16'd11);     exp_alu[1]  = 32'd11;
    prog[5]  = rr(5'd12, 5'd10, 5'd11, 6'h20);      exp_alu[5]  = 32'd21;
    prog[6]  = rr(5'd12, 5'd10, 5'd13, 6'h22);      exp_alu[6]  = 32'd1;
    prog[7]  = rr(5'd10, 5'd12, 5'd14, 6'h24);      exp_alu[7]  = 32'd10;
    prog[8]  = rr(5'd12, 5'd10, 5'd15, 6'h25);      exp_alu[8]  = 32'd11;
    prog[9]  = ri(6'h2b, 5'd10, 5'd11, 16'd0);      exp_alu[9]  = 32'd10;
    prog[10] = ri(6'h08, 5'd0,  5'd19, 16'h7fff);   exp_alu[10] = 32'h0000_7fff;
    prog[11] = ri(6'h08, 5'd0,  5'd22, 16'd5);      exp_alu[11] = 32'd5;
    prog[13] = ri(6'h23, 5'd10, 5'd16, 16'd0);      exp_alu[13] = 32'd10;
    prog[14] = rr(5'd22, 5'd0,  5'd0,  6'h20);      exp_alu[14] = 32'd0;
    prog[15] = rr(5'd22, 5'd0,  5'd0,  6'h20);      exp_alu[15] = 32'd5;
    prog[16] = ri(6'h08, 5'd19, 5'd19, 16'h6000);   exp_alu[16] = 32'h0000_dfff;
    prog[17] = rr(5'd13, 5'd0,  5'd0,  6'h25);      exp_alu[17] = 32'd1;
    prog[18] = rr(5'd14, 5'd0,  5'd0,  6'h25);      exp_alu[18] = 32'd10;
    prog[19] = rr(5'd15, 5'd0,  5'd0,  6'h25);      exp_alu[19] = 32'd11;
    prog[20] = ri(6'h08, 5'd19, 5'd19, 16'h6000);   exp_alu[20] = 32'h0001_3fff;
    prog[21] = rr(5'd16, 5'd0,  5'd0,  6'h25);      exp_alu[21] = 32'd21;
    prog[22] = ri(6'h08, 5'd0,  5'd23, 16'hffff);   exp_alu[22] = 32'hffff_ffff;
    prog[24] = ri(6'h08, 5'd19, 5'd19, 16'h6000);   exp_alu[24] = 32'h0001_9fff;
    prog[25] = ri(6'h08, 5'd0,  5'd0,  16'd7);      exp_alu[25] = 32'd7;
    prog[28] = ri(6'h08, 5'd19, 5'd19, 16'h6000);   exp_alu[28] = 32'h0001_ffff;
    prog[29] = rr(5'd0,  5'd0,  5'd0,  6'h20);      exp_alu[29] = 32'd0;
    prog[30] = 32'hffff_ffff;                       exp_alu[30] = 32'd0;
    prog[31] = rr(5'd10, 5'd12, 5'd10, 6'h2a);      exp_alu[31] = 32'd0;
    prog[32] = ri(6'h2b, 5'd10, 5'd19, 16'd0);      exp_alu[32] = 32'd10;
    prog[33] = ri(6'h2b, 5'd23, 5'd19, 16'd0);      exp_alu[33] = 32'hffff_ffff;
    prog[34] = ri(6'h21, 5'd10, 5'd17, 16'd0);      exp_alu[34] = 32'd10;
    prog[35] = ri(6'h25, 5'd10, 5'd18, 16'd0);      exp_alu[35] = 32'd10;
    prog[36] = ri(6'h21, 5'd10, 5'd20, 16'd2);      exp_alu[36] = 32'd12;
    prog[37] = ri(6'h25, 5'd10, 5'd21, 16'd1);      exp_alu[37] = 32'd11;
    prog[38] = ri(6'h25, 5'd0,  5'd25, 16'd0);      exp_alu[38] = 32'd0;
    prog[39] = ri(6'h23, 5'd23, 5'd26, 16'd0);      exp_alu[39] = 32'hffff_ffff;
    prog[40] = rr(5'd10, 5'd0,  5'd0,  6'h25);      exp_alu[40] = 32'd10;
    prog[41] = rr(5'd17, 5'd0,  5'd0,  6'h25);      exp_alu[41] = 32'hffff_ffff;
    prog[42] = rr(5'd18, 5'd0,  5'd0,  6'h25);      exp_alu[42] = 32'h0000_ffff;
    prog[43] = rr(5'd20, 5'd0,  5'd0,  6'h25);      exp_alu[43] = 32'h0000_0001;
    prog[44] = rr(5'd21, 5'd0,  5'd0,  6'h25);      exp_alu[44] = 32'h0000_01ff;
    prog[45] = rr(5'd25, 5'd0,  5'd0,  6'h25);      exp_alu[45] = 32'h0000_01ff;
    prog[46] = rr(5'd26, 5'd0,  5'd0,  6'h25);      exp_alu[46] = 32'h0001_ffff;
    prog[47] = ri(6'h21, 5'd23, 5'd27, 16'hffff);   exp_alu[47] = 32'hffff_fffe;
    prog[51] = rr(5'd27, 5'd0,  5'd0,  6'h25);      exp_alu[51] = 32'hffff_ff00;
    prog[52] = rr(5'd0,  5'd10, 5'd0,  6'h22);      exp_alu[52] = 32'hffff_fff6;

    for (int k = 0; k < 64; k++) begin
      for (int b = 0; b < 4; b++) begin
        imem[8'(4 * k + b)] = prog[k][8*b +: 8];
      end
    end

    repeat (2) @(posedge clk);
    #1;
    chk("reset next_instruction", next_instruction, 32'h0);
    chk("reset alu_result", alu_result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_pass(45, "run1");

    #2 rst = 1'b1;
    #1;
    chk("midreset next_instruction", next_instruction, 32'h0);
    chk("midreset alu_result", alu_result, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_pass(56, "run2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
